// File: rtl/mc_port_arbiter.sv
// Shares the single mc_wrapper request port between NREQ requesters: round-robin read and
// write arbiters, requester index stamped into read ids, per-requester outstanding-read limits.
module mc_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDX_W     = $clog2(NREQ),
    parameter int ID_W      = 8,
    parameter int UID_W     = ID_W - IDX_W,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_arvalid,
    output logic [NREQ-1:0]          req_arready,
    input  logic [NREQ*UID_W-1:0]    req_arid,
    input  logic [NREQ*ADDR_W-1:0]   req_araddr,
    input  logic [NREQ-1:0]          req_wvalid,
    output logic [NREQ-1:0]          req_wready,
    input  logic [NREQ*ID_W-1:0]     req_wid,
    input  logic [NREQ*ADDR_W-1:0]   req_waddr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_rvalid,
    input  logic [NREQ-1:0]          req_rready,
    output logic [UID_W-1:0]         req_rid,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ID_W-1:0]          awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [ID_W-1:0]          wid,
    output logic [DATA_W-1:0]        wdata,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [ID_W-1:0]          arid,
    output logic [ADDR_W-1:0]        araddr,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [ID_W-1:0]          rid,
    input  logic [DATA_W-1:0]        rdata
);

    localparam int         CNT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_SEND = 1'b1;

    // Returns {found, index} of the first set bit of m at or after ptr; NREQ is a power of two
    // so the index sum wraps naturally.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] m,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ptr + IDX_W'(k);
            if (m[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    logic [IDX_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt [NREQ];
    logic [NREQ-1:0]  rd_elig;
    logic [NREQ-1:0]  rd_inc;
    logic [NREQ-1:0]  rd_dec;
    logic             rd_any;
    logic [IDX_W-1:0] rd_idx;
    logic             ar_load;
    logic [IDX_W-1:0] rsp_idx;

    // NOTE: every signal driven in always_comb gets a default first so no path infers a latch.
    always_comb begin
        rd_elig = '0;
        for (int i = 0; i < NREQ; i++)
            rd_elig[i] = req_arvalid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
        {rd_any, rd_idx} = rr_pick(rd_elig, rd_ptr);
        ar_load     = !arvalid || arready;
        req_arready = '0;
        if (rst_n && rd_any && ar_load) req_arready[rd_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            rd_ptr  <= '0;
        end else if (rd_any && ar_load) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            arvalid <= 1'b1;
            arid    <= {rd_idx, req_arid[rd_idx*UID_W +: UID_W]};
            araddr  <= req_araddr[rd_idx*ADDR_W +: ADDR_W];
            rd_ptr  <= rd_idx + 1'b1;
        end else if (arready) begin
            arvalid <= 1'b0;
        end
    end

    // Response routing is purely combinational; the owning requester sits in the id's top bits.
    assign rsp_idx   = rid[ID_W-1 -: IDX_W];
    assign rready    = rst_n && req_rready[rsp_idx];
    assign req_rid   = rid[UID_W-1:0];
    assign req_rdata = rdata;

    always_comb begin
        req_rvalid = '0;
        if (rst_n) req_rvalid[rsp_idx] = rvalid;
        rd_inc = req_arvalid & req_arready;
        for (int i = 0; i < NREQ; i++)
            rd_dec[i] = req_rvalid[i] && req_rready[i] && (cnt[i] != '0);
    end

    // A spurious response at cnt=0 is still routed but does not move the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rd_inc[i] && !rd_dec[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (rd_dec[i] && !rd_inc[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    logic [0:0]       wr_state;
    logic [IDX_W-1:0] wr_ptr;
    logic             wr_any;
    logic [IDX_W-1:0] wr_idx;
    logic             aw_pend;
    logic             w_pend;
    logic             aw_pend_nxt;
    logic             w_pend_nxt;
    logic [ID_W-1:0]  wr_id;

    always_comb begin
        {wr_any, wr_idx} = rr_pick(req_wvalid, wr_ptr);
        req_wready = '0;
        if (rst_n && wr_state == W_IDLE && wr_any) req_wready[wr_idx] = 1'b1;
        aw_pend_nxt = aw_pend && !awready;
        w_pend_nxt  = w_pend && !wready;
    end

    assign awvalid = aw_pend;
    assign wvalid  = w_pend;
    assign awid    = wr_id;
    assign wid     = wr_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            wr_ptr   <= '0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            wr_id    <= '0;
            awaddr   <= '0;
            wdata    <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_any) begin
                        wr_id    <= req_wid[wr_idx*ID_W +: ID_W];
                        awaddr   <= req_waddr[wr_idx*ADDR_W +: ADDR_W];
                        wdata    <= req_wdata[wr_idx*DATA_W +: DATA_W];
                        wr_ptr   <= wr_idx + 1'b1;
                        aw_pend  <= 1'b1;
                        w_pend   <= 1'b1;
                        wr_state <= W_SEND;
                    end
                end
                default: begin
                    aw_pend <= aw_pend_nxt;
                    w_pend  <= w_pend_nxt;
                    if (!aw_pend_nxt && !w_pend_nxt) wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Randomized scoreboard bench for mc_port_arbiter: a transaction-level model predicts grants,
// downstream beats and routed responses; a separate monitor compares them against the DUT.
module tb_mc_port_arbiter;

    localparam int NREQ      = 4;
    localparam int IDX_W     = $clog2(NREQ);
    localparam int ID_W      = 8;
    localparam int UID_W     = ID_W - IDX_W;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int MAX_OUTST = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NREQ-1:0]        req_arvalid, req_arready;
    logic [NREQ*UID_W-1:0]  req_arid;
    logic [NREQ*ADDR_W-1:0] req_araddr;
    logic [NREQ-1:0]        req_wvalid, req_wready;
    logic [NREQ*ID_W-1:0]   req_wid;
    logic [NREQ*ADDR_W-1:0] req_waddr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_rvalid, req_rready;
    logic [UID_W-1:0]       req_rid;
    logic [DATA_W-1:0]      req_rdata;
    logic                   awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [ID_W-1:0]        awid, wid, arid, rid;
    logic [ADDR_W-1:0]      awaddr, araddr;
    logic [DATA_W-1:0]      wdata, rdata;

    mc_port_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_arready(req_arready), .req_arid(req_arid),
        .req_araddr(req_araddr), .req_wvalid(req_wvalid), .req_wready(req_wready),
        .req_wid(req_wid), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rid(req_rid),
        .req_rdata(req_rdata), .awvalid(awvalid), .awready(awready), .awid(awid),
        .awaddr(awaddr), .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct {
        logic [NREQ-1:0]   vec;
        logic [UID_W-1:0]  uid;
        logic [DATA_W-1:0] data;
        logic              rdy;
    } rsp_t;

    beat_t ar_q[$], aw_q[$], w_q[$];
    rsp_t  rsp_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference state, in transaction terms
    int m_rd_ptr, m_wr_ptr;
    int m_cnt [NREQ];
    bit m_full, m_wsend, m_aw_pend, m_w_pend;
    bit exp_arvalid, exp_awvalid, exp_wvalid;
    int rsp_tgt;
    logic [NREQ-1:0] ar_acc, w_acc;
    int p_req, p_ard, p_rsp, p_awr;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [NREQ-1:0] m, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_step();
        logic [NREQ-1:0] elig, expv;
        int g, gw;
        beat_t b;
        for (int i = 0; i < NREQ; i++) elig[i] = req_arvalid[i] && (m_cnt[i] < MAX_OUTST);
        g = (!m_full || arready) ? first_from(elig, m_rd_ptr) : -1;
        expv = '0;
        if (g >= 0) expv[g] = 1'b1;
        check("req_arready", req_arready, expv);
        ar_acc      = req_arready;
        exp_arvalid = m_full;
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_tgt == i && req_rready[i] && m_cnt[i] > 0) m_cnt[i]--;
            if (g == i) m_cnt[i]++;
        end
        if (g >= 0) begin
            b.id   = {IDX_W'(g), req_arid[g*UID_W +: UID_W]};
            b.addr = req_araddr[g*ADDR_W +: ADDR_W];
            b.data = '0;
            ar_q.push_back(b);
            m_rd_ptr = (g + 1) % NREQ;
            m_full   = 1'b1;
        end else if (arready) begin
            m_full = 1'b0;
        end

        exp_awvalid = m_aw_pend;
        exp_wvalid  = m_w_pend;
        gw = m_wsend ? -1 : first_from(req_wvalid, m_wr_ptr);
        expv = '0;
        if (gw >= 0) expv[gw] = 1'b1;
        check("req_wready", req_wready, expv);
        w_acc = req_wready;
        if (gw >= 0) begin
            b.id   = req_wid[gw*ID_W +: ID_W];
            b.addr = req_waddr[gw*ADDR_W +: ADDR_W];
            b.data = req_wdata[gw*DATA_W +: DATA_W];
            aw_q.push_back(b);
            w_q.push_back(b);
            m_wr_ptr  = (gw + 1) % NREQ;
            m_wsend   = 1'b1;
            m_aw_pend = 1'b1;
            m_w_pend  = 1'b1;
        end else if (m_wsend) begin
            if (awready) m_aw_pend = 1'b0;
            if (wready)  m_w_pend  = 1'b0;
            if (!m_aw_pend && !m_w_pend) m_wsend = 1'b0;
        end
    endtask

    task automatic drive_cycle();
        int r;
        rsp_t e;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ar_acc[i] || !req_arvalid[i]) begin
                req_arvalid[i] = ($urandom_range(99) < p_req);
                req_arid[i*UID_W +: UID_W]     = UID_W'($urandom);
                req_araddr[i*ADDR_W +: ADDR_W] = $urandom;
            end
            if (w_acc[i] || !req_wvalid[i]) begin
                req_wvalid[i] = ($urandom_range(99) < p_req);
                req_wid[i*ID_W +: ID_W]       = ID_W'($urandom);
                req_waddr[i*ADDR_W +: ADDR_W] = $urandom;
                req_wdata[i*DATA_W +: DATA_W] = rand_data();
            end
            req_rready[i] = ($urandom_range(3) != 0);
        end
        arready = ($urandom_range(99) < p_ard);
        awready = ($urandom_range(99) < p_awr);
        wready  = ($urandom_range(99) < p_awr);
        rvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        rsp_tgt = -1;
        if ($urandom_range(99) < p_rsp) begin
            r = $urandom_range(NREQ - 1);
            if (m_cnt[r] > 0 || $urandom_range(9) == 0) begin
                e.vec    = '0;
                e.vec[r] = 1'b1;
                e.uid    = UID_W'($urandom);
                e.data   = rand_data();
                e.rdy    = req_rready[r];
                rvalid   = 1'b1;
                rid      = {IDX_W'(r), e.uid};
                rdata    = e.data;
                rsp_tgt  = r;
                rsp_q.push_back(e);
            end
        end
        #1;
        model_step();
    endtask

    task automatic clear_all();
        req_arvalid = '0; req_arid = '0; req_araddr = '0;
        req_wvalid = '0; req_wid = '0; req_waddr = '0; req_wdata = '0;
        req_rready = '0; arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rid = '0; rdata = '0; rsp_tgt = -1;
        ar_acc = '0; w_acc = '0;
        m_rd_ptr = 0; m_wr_ptr = 0; m_full = 1'b0; m_wsend = 1'b0;
        m_aw_pend = 1'b0; m_w_pend = 1'b0;
        exp_arvalid = 1'b0; exp_awvalid = 1'b0; exp_wvalid = 1'b0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        ar_q.delete(); aw_q.delete(); w_q.delete(); rsp_q.delete();
    endtask

    // Reset is asserted with whatever requests are pending still on the inputs, so the
    // immediate checks also show that handshake outputs are suppressed.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_req_arready", req_arready, '0);
        check("rst_req_wready", req_wready, '0);
        check("rst_req_rvalid", req_rvalid, '0);
        check("rst_arid", arid, '0);
        check("rst_araddr", araddr, '0);
        check("rst_awaddr", awaddr, '0);
        check("rst_wdata", wdata, '0);
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) drive_cycle();
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin : monitor
        rsp_t e;
        #2;
        if (rst_n) begin
            check("arvalid", arvalid, exp_arvalid);
            if (exp_arvalid && ar_q.size() > 0) begin
                check("arid", arid, ar_q[0].id);
                check("araddr", araddr, ar_q[0].addr);
                if (arready) void'(ar_q.pop_front());
            end
            check("awvalid", awvalid, exp_awvalid);
            if (exp_awvalid && aw_q.size() > 0) begin
                check("awid", awid, aw_q[0].id);
                check("awaddr", awaddr, aw_q[0].addr);
                if (awready) void'(aw_q.pop_front());
            end
            check("wvalid", wvalid, exp_wvalid);
            if (exp_wvalid && w_q.size() > 0) begin
                check("wid", wid, w_q[0].id);
                check("wdata", wdata, w_q[0].data);
                if (wready) void'(w_q.pop_front());
            end
            if (rvalid && rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                check("req_rvalid", req_rvalid, e.vec);
                check("req_rid", req_rid, e.uid);
                check("req_rdata", req_rdata, e.data);
                check("rready", rready, e.rdy);
            end else begin
                check("req_rvalid_idle", req_rvalid, '0);
            end
        end
    end

    initial begin
        int guard;
        clear_all();
        #1 rst_n = 1'b0;
        do_reset();

        p_req = 50; p_ard = 70; p_rsp = 40; p_awr = 50;
        run(300);
        // Fill every requester to its outstanding limit, then stall the read port.
        p_req = 90; p_ard = 100; p_rsp = 0; p_awr = 30;
        run(40);
        p_ard = 0;
        run(20);
        p_ard = 60; p_rsp = 50;
        run(100);
        // Saturated: back-to-back reads, simultaneous grant and response per requester.
        p_req = 100; p_ard = 100; p_rsp = 80; p_awr = 100;
        run(200);

        // Reset while a write is in W_SEND and a read is parked on the port.
        p_req = 100; p_ard = 20; p_rsp = 20; p_awr = 10;
        guard = 0;
        do begin
            drive_cycle();
            guard++;
        end while (!(m_wsend && m_full) && guard < 300);
        if (!(m_wsend && m_full)) begin
            vectors++;
            miscompares++;
            $display("FAIL midop_setup: write send with parked read not reached within %0d cycles", guard);
        end
        do_reset();

        p_req = 60; p_ard = 70; p_rsp = 50; p_awr = 60;
        run(300);
        p_req = 0; p_rsp = 100; p_ard = 100; p_awr = 100;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
